sudoku_move_sequencer: RTL and testbench

//  Front-end controller for the sudoku game core. Takes user moves (row, col, value) over a

---
 rtl/sudoku_pkg.sv | 40 ++++
 rtl/sudoku_move_fifo.sv | 58 +++++
 rtl/sudoku_move_sequencer.sv | 137 +++++++++++++
 tb/tb_sudoku_move_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared types for the sudoku move front-end: sequencer state, gap return code, move layout.
package sudoku_pkg;

   localparam int MOVE_W = 6;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_NEWG = 4'd1,
      ST_DIFF = 4'd2,
      ST_PLAY = 4'd3,
      ST_ROW  = 4'd4,
      ST_COL  = 4'd5,
      ST_VAL  = 4'd6,
      ST_GAP  = 4'd7,
      ST_DONE = 4'd8
   } state_t;

   typedef enum logic [1:0] {
      RET_DIFF = 2'd0,
      RET_COL  = 2'd1,
      RET_VAL  = 2'd2,
      RET_PLAY = 2'd3
   } ret_t;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
      logic [1:0] val;
   } move_t;

   function automatic state_t ret_target(input ret_t r);
      case (r)
         RET_DIFF: return ST_DIFF;
         RET_COL:  return ST_COL;
         RET_VAL:  return ST_VAL;
         default:  return ST_PLAY;
      endcase
   endfunction

endpackage

// File: rtl/sudoku_move_fifo.sv
// Small synchronous FIFO for buffered moves: flush, occupancy count, full/empty flags.
module sudoku_move_fifo
   import sudoku_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      push,
   input  logic                      pop,
   input  logic [MOVE_W-1:0]         wdata,
   output logic [MOVE_W-1:0]         rdata,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty
);

   localparam int AW = $clog2(DEPTH);

   logic [MOVE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: storage is deliberately left out of reset; count and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sudoku_move_sequencer.sv
// Serialises buffered (row,col,val) moves into the game core's enter/diff_cell_val beats,
// with new-game and difficulty setup, abort on new-game request and halt once solved.
module sudoku_move_sequencer
   import sudoku_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic                          in_clk,
   input  logic                          in_rst_n,
   input  logic                          in_game_req,
   input  logic [1:0]                    in_diff,
   input  logic                          in_move_valid,
   output logic                          out_move_ready,
   input  logic [1:0]                    in_move_row,
   input  logic [1:0]                    in_move_col,
   input  logic [1:0]                    in_move_val,
   input  logic                          in_solved,
   output logic                          out_new_game,
   output logic                          out_enter,
   output logic [1:0]                    out_diff_cell_val,
   output logic                          out_busy,
   output logic [$clog2(FIFO_DEPTH):0]   out_fifo_count
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t           state;
   state_t           next_state;
   ret_t             ret;
   logic [GAP_W-1:0] gap_cnt;
   logic [1:0]       diff_q;
   logic             armed;
   move_t            cur;
   move_t            head;
   move_t            in_move;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_flush;
   logic             fifo_full;
   logic             fifo_empty;

   assign in_move = '{row: in_move_row, col: in_move_col, val: in_move_val};

   sudoku_move_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (in_clk),
      .rst_n (in_rst_n),
      .flush (fifo_flush),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (in_move),
      .rdata (head),
      .count (out_fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) state <= ST_IDLE;
      else           state <= next_state;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      if (in_game_req) begin
         next_state = ST_NEWG;
      end else begin
         case (state)
            ST_NEWG, ST_DIFF,
            ST_ROW, ST_COL, ST_VAL: next_state = ST_GAP;
            ST_PLAY: begin
               if (in_solved)        next_state = ST_DONE;
               else if (!fifo_empty) next_state = ST_ROW;
            end
            ST_GAP:  if (gap_cnt == '0) next_state = ret_target(ret);
            default: next_state = state;
         endcase
      end
   end

   always_comb begin
      out_new_game   = (state == ST_NEWG);
      out_enter      = (state inside {ST_DIFF, ST_ROW, ST_COL, ST_VAL});
      out_busy       = !(state == ST_IDLE || (state == ST_PLAY && fifo_empty));
      out_move_ready = !in_game_req && !fifo_full &&
                       ((state inside {ST_PLAY, ST_ROW, ST_COL, ST_VAL}) ||
                        (state == ST_GAP && armed));
      fifo_push      = in_move_valid && out_move_ready;
      fifo_pop       = (state == ST_PLAY) && !in_game_req && !in_solved && !fifo_empty;
      fifo_flush     = in_game_req || (state == ST_PLAY && in_solved);
   end

   // Gap timing, return target and the "move phase reached" flag that gates GAP acceptance.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         gap_cnt <= '0;
         ret     <= RET_DIFF;
         armed   <= 1'b0;
         diff_q  <= '0;
         cur     <= '0;
      end else begin
         if (state != ST_GAP)    gap_cnt <= GAP_W'(GAP_CYCLES - 1);
         else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
         case (state)
            ST_NEWG: ret <= RET_DIFF;
            ST_DIFF: ret <= RET_PLAY;
            ST_ROW:  ret <= RET_COL;
            ST_COL:  ret <= RET_VAL;
            ST_VAL:  ret <= RET_PLAY;
            default: ret <= ret;
         endcase
         if (next_state == ST_NEWG)  armed <= 1'b0;
         else if (state == ST_PLAY)  armed <= 1'b1;
         if (in_game_req) diff_q <= in_diff;
         if (state == ST_PLAY && next_state == ST_ROW) cur <= head;
      end
   end

   // Payload is loaded on entry to each beat so it is valid with enter and held through GAP.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_diff_cell_val <= '0;
      end else begin
         case (next_state)
            ST_IDLE, ST_NEWG: out_diff_cell_val <= '0;
            ST_DIFF:          out_diff_cell_val <= diff_q;
            ST_ROW:           out_diff_cell_val <= head.row;
            ST_COL:           out_diff_cell_val <= cur.col;
            ST_VAL:           out_diff_cell_val <= cur.val;
            default:          out_diff_cell_val <= out_diff_cell_val;
         endcase
      end
   end

endmodule

// File: tb/tb_sudoku_move_sequencer.sv
// Self-checking bench: timeline/queue reference model compared every cycle, plus directed scenarios.
module tb_sudoku_move_sequencer;

   localparam int DEPTH = 4;
   localparam int G     = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_game_req = 1'b0;
   logic [1:0] in_diff = '0;
   logic       in_move_valid = 1'b0;
   logic [1:0] in_move_row = '0;
   logic [1:0] in_move_col = '0;
   logic [1:0] in_move_val = '0;
   logic       in_solved = 1'b0;
   logic       out_move_ready;
   logic       out_new_game;
   logic       out_enter;
   logic [1:0] out_diff_cell_val;
   logic       out_busy;
   logic [2:0] out_fifo_count;

   always #5 clk = ~clk;

   sudoku_move_sequencer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(G)) dut (
      .in_clk            (clk),
      .in_rst_n          (rst_n),
      .in_game_req       (in_game_req),
      .in_diff           (in_diff),
      .in_move_valid     (in_move_valid),
      .out_move_ready    (out_move_ready),
      .in_move_row       (in_move_row),
      .in_move_col       (in_move_col),
      .in_move_val       (in_move_val),
      .in_solved         (in_solved),
      .out_new_game      (out_new_game),
      .out_enter         (out_enter),
      .out_diff_cell_val (out_diff_cell_val),
      .out_busy          (out_busy),
      .out_fifo_count    (out_fifo_count)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a script of expected per-cycle beats plus a move queue.
   typedef enum {M_IDLE, M_PLAY, M_DONE} mode_t;
   typedef struct packed {bit ng; bit en; bit [1:0] pay; bit acc;} beat_t;

   mode_t     mode = M_IDLE;
   beat_t     script[$];
   bit [5:0]  q[$];
   int        last_pay = 0;
   int        obs_ng, obs_en, obs_pay, obs_rdy, obs_busy, obs_cnt;

   function automatic void add_beat(input bit [1:0] pay, input bit acc);
      script.push_back('{ng: 1'b0, en: 1'b1, pay: pay, acc: acc});
      for (int k = 0; k < G; k++) script.push_back('{ng: 1'b0, en: 1'b0, pay: pay, acc: acc});
   endfunction

   function automatic void model_reset();
      mode = M_IDLE;
      script.delete();
      q.delete();
      last_pay = 0;
   endfunction

   task automatic model_check();
      int    e_ng, e_en, e_pay, e_rdy, e_busy, e_cnt;
      bit    acc;
      bit [5:0] hd;
      e_ng = 0; e_en = 0; e_pay = last_pay; e_rdy = 0; e_busy = 1;
      e_cnt = q.size();
      if (mode == M_IDLE) begin
         e_pay = 0; e_busy = 0;
      end else if (script.size() > 0) begin
         e_ng  = script[0].ng;
         e_en  = script[0].en;
         e_pay = script[0].pay;
         e_rdy = int'(script[0].acc && q.size() < DEPTH && !in_game_req);
      end else if (mode == M_PLAY) begin
         e_rdy  = int'(q.size() < DEPTH && !in_game_req);
         e_busy = int'(q.size() != 0);
      end
      obs_ng = out_new_game; obs_en = out_enter; obs_pay = out_diff_cell_val;
      obs_rdy = out_move_ready; obs_busy = out_busy; obs_cnt = out_fifo_count;
      check("new_game", out_new_game, e_ng);
      check("enter", out_enter, e_en);
      check("payload", out_diff_cell_val, e_pay);
      check("ready", out_move_ready, e_rdy);
      check("busy", out_busy, e_busy);
      check("count", out_fifo_count, e_cnt);
      last_pay = e_pay;
      acc = in_move_valid && (e_rdy != 0);
      if (in_game_req) begin
         q.delete();
         script.delete();
         script.push_back('{ng: 1'b1, en: 1'b0, pay: 2'd0, acc: 1'b0});
         for (int k = 0; k < G; k++) script.push_back('{ng: 1'b0, en: 1'b0, pay: 2'd0, acc: 1'b0});
         add_beat(in_diff, 1'b0);
         mode = M_PLAY;
      end else if (mode == M_IDLE || mode == M_DONE) begin
         // nothing moves
      end else if (script.size() > 0) begin
         void'(script.pop_front());
         if (acc) q.push_back({in_move_row, in_move_col, in_move_val});
      end else if (in_solved) begin
         mode = M_DONE;
         q.delete();
      end else begin
         bit had = (q.size() > 0);
         if (had) hd = q.pop_front();
         if (acc) q.push_back({in_move_row, in_move_col, in_move_val});
         if (had) begin
            add_beat(hd[5:4], 1'b1);
            add_beat(hd[3:2], 1'b1);
            add_beat(hd[1:0], 1'b1);
         end
      end
   endtask

   task automatic drive(input bit gr, input bit [1:0] d, input bit v, input bit [5:0] mv, input bit s);
      @(posedge clk);
      #1;
      in_game_req   = gr;
      in_diff       = d;
      in_move_valid = v;
      {in_move_row, in_move_col, in_move_val} = mv;
      in_solved     = s;
      @(negedge clk);
      model_check();
   endtask

   task automatic idle(input bit s);
      drive(1'b0, 2'd0, 1'b0, 6'd0, s);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      in_game_req = 0; in_move_valid = 0; in_solved = 0;
      #1;
      check("rst_enter", out_enter, 0);
      check("rst_new_game", out_new_game, 0);
      check("rst_ready", out_move_ready, 0);
      check("rst_count", out_fifo_count, 0);
      check("rst_payload", out_diff_cell_val, 0);
      check("rst_busy", out_busy, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int       got[$];
      int       at[$];
      bit [5:0] mv[5];
      bit [5:0] ma, mb;
      int       i, n;
      bit       saw_stall;
      bit       solved_lvl;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: idle after reset
      repeat (20) idle(1'b0);
      check("idle_ready", obs_rdy, 0);
      check("idle_enter", obs_en, 0);

      // 2: new game with difficulty 2; cycle 0 is the request
      drive(1'b1, 2'd2, 1'b0, 6'd0, 1'b0);
      idle(1'b0);
      check("c1_new_game", obs_ng, 1);
      idle(1'b0);
      idle(1'b0);
      check("c3_enter", obs_en, 1);
      check("c3_payload", obs_pay, 2);
      idle(1'b0);
      check("c4_ready", obs_rdy, 0);
      idle(1'b0);
      check("c5_ready", obs_rdy, 1);

      // 3: single move (1,2,3)
      drive(1'b0, 2'd0, 1'b1, {2'd1, 2'd2, 2'd3}, 1'b0);
      check("c6_accept", obs_rdy, 1);
      idle(1'b0);
      check("c7_count", obs_cnt, 1);
      for (int c = 8; c < 16; c++) begin
         idle(1'b0);
         if (obs_en) begin got.push_back(obs_pay); at.push_back(c); end
      end
      check("mv_beats", got.size(), 3);
      if (got.size() == 3) begin
         check("mv_row", got[0], 1);
         check("mv_col", got[1], 2);
         check("mv_val", got[2], 3);
         check("mv_space1", at[1] - at[0], 2);
         check("mv_space2", at[2] - at[1], 2);
      end
      check("mv_count_end", obs_cnt, 0);

      // 4: five back-to-back moves
      foreach (mv[k]) mv[k] = 6'($urandom);
      got.delete();
      i = 0; n = 0; saw_stall = 0;
      while (!(i == 5 && got.size() == 15) && n < 200) begin
         if (i < 5) drive(1'b0, 2'd0, 1'b1, mv[i], 1'b0);
         else       idle(1'b0);
         if (i < 5 && obs_rdy) i++;
         if (obs_cnt == DEPTH && obs_rdy == 0) saw_stall = 1;
         if (obs_en) got.push_back(obs_pay);
         n++;
      end
      check("b2b_accepted", i, 5);
      check("b2b_beats", got.size(), 15);
      check("b2b_stall_seen", saw_stall, 1);
      if (got.size() == 15)
         for (int k = 0; k < 5; k++)
            check("b2b_move", {got[3*k][1:0], got[3*k+1][1:0], got[3*k+2][1:0]}, mv[k]);

      // 5: solved during COL beat
      idle(1'b0);
      idle(1'b0);
      check("s5_play_idle", obs_busy, 0);
      ma = {2'd3, 2'd1, 2'd2};
      mb = {2'd0, 2'd3, 2'd1};
      drive(1'b0, 2'd0, 1'b1, ma, 1'b0);
      drive(1'b0, 2'd0, 1'b1, mb, 1'b0);
      idle(1'b0);
      check("s5_row", obs_pay, 3);
      idle(1'b0);
      idle(1'b1);
      check("s5_col_enter", obs_en, 1);
      check("s5_col", obs_pay, 1);
      idle(1'b1);
      idle(1'b1);
      check("s5_val_enter", obs_en, 1);
      check("s5_val", obs_pay, 2);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      check("s5_done_count", obs_cnt, 0);
      check("s5_done_ready", obs_rdy, 0);
      repeat (5) idle(1'b0);
      check("s5_done_quiet", obs_en, 0);

      // 6: abort during ROW with a same-cycle move offer
      drive(1'b1, 2'd1, 1'b0, 6'd0, 1'b0);
      repeat (4) idle(1'b0);
      drive(1'b0, 2'd0, 1'b1, {2'd2, 2'd2, 2'd2}, 1'b0);
      idle(1'b0);
      drive(1'b1, 2'd3, 1'b1, {2'd1, 2'd1, 2'd1}, 1'b0);
      check("a6_row_enter", obs_en, 1);
      check("a6_ready", obs_rdy, 0);
      idle(1'b0);
      check("a6_new_game", obs_ng, 1);
      check("a6_count", obs_cnt, 0);
      repeat (6) idle(1'b0);

      // Randomised traffic with one mid-run asynchronous reset
      solved_lvl = 0;
      for (int k = 0; k < 3000; k++) begin
         if (k == 1500) async_reset();
         if ($urandom_range(0, 39) == 0) solved_lvl = !solved_lvl;
         drive(($urandom_range(0, 59) == 0), 2'($urandom), ($urandom_range(0, 9) < 7),
               6'($urandom), solved_lvl);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
